// File: rtl/piso_pkg.sv
// Shared types and sizing helpers for the parallel-in serial-out serializer.
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Bit-counter width: enough to count 0..width-1, never narrower than one bit.
  function automatic int calc_cnt_w(input int width);
    int w;
    w = $clog2(width);
    if (w < 1) begin
      w = 1;
    end else begin
      w = w;
    end
    return w;
  endfunction

endpackage

// File: rtl/piso_hold_buf.sv
// One-word holding buffer: captures the next word while the current one
// shifts out, and tells the upstream stage whether it can take another word.
module piso_hold_buf #(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_wr,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_rd,
  output logic [WIDTH-1:0] o_hold,
  output logic             o_full,
  output logic             o_ready
);

  logic [WIDTH-1:0] r_hold;
  logic             r_full;

  // Capture a word on write, release the slot on drain; the two never coincide
  // because writes are only possible while the slot is empty.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hold <= {WIDTH{1'b0}};
      r_full <= 1'b0;
    end else if (i_wr) begin
      r_hold <= i_din;
      r_full <= 1'b1;
    end else if (i_rd) begin
      r_full <= 1'b0;
    end else begin
      r_full <= r_full;
    end
  end

  assign o_hold  = r_hold;
  assign o_full  = r_full;
  assign o_ready = ~r_full;

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out stage: emits each WIDTH-bit word one bit per clock,
// with a one-word holding buffer so back-to-back words stream without gaps.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             sout_first,
  output logic             sout_last
);

  localparam int              CNT_W    = calc_cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [WIDTH-1:0] r_sh;
  logic [WIDTH-1:0] w_sh_nxt;
  logic [WIDTH-1:0] w_shifted;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  logic [WIDTH-1:0] w_hold;
  logic             w_hold_full;
  logic             w_ready;
  logic             w_xfer;
  logic             w_at_last;
  logic             w_shifting;
  logic             w_hold_wr;
  logic             w_hold_rd;

  assign w_xfer     = din_valid & w_ready;
  assign w_shifting = (r_state == SHIFT);
  assign w_at_last  = (r_cnt == CNT_LAST);
  // A word arriving mid-word parks in the buffer; at the last-bit edge an
  // empty buffer lets the word go straight into the shifter instead.
  assign w_hold_wr  = w_xfer & w_shifting & ~w_at_last;
  assign w_hold_rd  = w_shifting & w_at_last & w_hold_full;

  piso_hold_buf #(
    .WIDTH (WIDTH)
  ) u_hold_buf (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_wr    (w_hold_wr),
    .i_din   (din),
    .i_rd    (w_hold_rd),
    .o_hold  (w_hold),
    .o_full  (w_hold_full),
    .o_ready (w_ready)
  );

  // Move the shifter one position toward the output end, zero-filling behind.
  always_comb begin
    w_shifted = {WIDTH{1'b0}};
    if (MSB_FIRST) begin
      w_shifted = {r_sh[WIDTH-2:0], 1'b0};
    end else begin
      w_shifted = {1'b0, r_sh[WIDTH-1:1]};
    end
  end

  // Next-state logic: load on transfer when idle, shift mid-word, and at the
  // last bit reload from the buffer first, then from din, else go idle.
  always_comb begin
    w_state_nxt = r_state;
    w_sh_nxt    = r_sh;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_xfer) begin
          w_sh_nxt    = din;
          w_cnt_nxt   = {CNT_W{1'b0}};
          w_state_nxt = SHIFT;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      SHIFT: begin
        if (!w_at_last) begin
          w_sh_nxt  = w_shifted;
          w_cnt_nxt = r_cnt + CNT_ONE;
        end else if (w_hold_full) begin
          w_sh_nxt  = w_hold;
          w_cnt_nxt = {CNT_W{1'b0}};
        end else if (w_xfer) begin
          w_sh_nxt  = din;
          w_cnt_nxt = {CNT_W{1'b0}};
        end else begin
          w_sh_nxt    = {WIDTH{1'b0}};
          w_cnt_nxt   = {CNT_W{1'b0}};
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_sh_nxt    = {WIDTH{1'b0}};
        w_cnt_nxt   = {CNT_W{1'b0}};
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State, shifter and bit counter registers; reset drops any partial word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_sh    <= {WIDTH{1'b0}};
      r_cnt   <= {CNT_W{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_sh    <= w_sh_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign din_ready  = w_ready;
  assign sout       = MSB_FIRST ? r_sh[WIDTH-1] : r_sh[0];
  assign sout_valid = w_shifting;
  assign sout_first = w_shifting & (r_cnt == {CNT_W{1'b0}});
  assign sout_last  = w_shifting & w_at_last;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed testbench for piso_serializer: reset, single word, back-to-back
// words with buffer backpressure, async reset mid-word, LSB-first and 8-bit.
module tb_piso_serializer;

  logic       clk;
  logic       rst;
  logic [3:0] din;
  logic       din_valid;
  logic       din_ready, sout, sout_valid, sout_first, sout_last;

  logic [3:0] din_b;
  logic       din_valid_b;
  logic       din_ready_b, sout_b, sout_valid_b, sout_first_b, sout_last_b;

  logic [7:0] din_c;
  logic       din_valid_c;
  logic       din_ready_c, sout_c, sout_valid_c, sout_first_c, sout_last_c;

  int n_checks = 0;
  int n_errors = 0;

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) u_dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .sout(sout), .sout_valid(sout_valid), .sout_first(sout_first), .sout_last(sout_last)
  );

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) u_dut_lsb4 (
    .clk(clk), .rst(rst), .din(din_b), .din_valid(din_valid_b), .din_ready(din_ready_b),
    .sout(sout_b), .sout_valid(sout_valid_b), .sout_first(sout_first_b), .sout_last(sout_last_b)
  );

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_dut_lsb8 (
    .clk(clk), .rst(rst), .din(din_c), .din_valid(din_valid_c), .din_ready(din_ready_c),
    .sout(sout_c), .sout_valid(sout_valid_c), .sout_first(sout_first_c), .sout_last(sout_last_c)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Check main DUT outputs against packed expectation {valid, sout, first, last, ready}.
  task automatic chk_out(input string tag, input logic [4:0] e);
    chk({tag, ".valid"}, {7'd0, sout_valid}, {7'd0, e[4]});
    chk({tag, ".sout"},  {7'd0, sout},       {7'd0, e[3]});
    chk({tag, ".first"}, {7'd0, sout_first}, {7'd0, e[2]});
    chk({tag, ".last"},  {7'd0, sout_last},  {7'd0, e[1]});
    chk({tag, ".ready"}, {7'd0, din_ready},  {7'd0, e[0]});
  endtask

  // Drive one cycle of input from a negedge, then check after the rising edge.
  task automatic step(input string tag, input logic v, input logic [3:0] d, input logic [4:0] e);
    din_valid = v;
    din       = v ? d : 4'bxxxx;
    @(posedge clk);
    @(negedge clk);
    chk_out(tag, e);
  endtask

  initial begin
    logic [0:3] exp_b;
    logic [0:7] exp_c;
    rst = 1'b0;
    din = 4'd0;  din_valid = 1'b0;
    din_b = 4'd0; din_valid_b = 1'b0;
    din_c = 8'd0; din_valid_c = 1'b0;

    // 1: reset held with random inputs, then release with no transfer.
    for (int i = 0; i < 6; i++) begin
      din       = 4'($urandom);
      din_valid = 1'($urandom);
      @(negedge clk);
      chk_out("rst_hold", 5'b00001);
    end
    din_valid = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step("post_rst_idle", 1'b0, 4'd0, 5'b00001);
    end

    // 2: single word 1010, MSB first.
    step("single_b0", 1'b1, 4'b1010, 5'b11101);
    step("single_b1", 1'b0, 4'd0,    5'b10001);
    step("single_b2", 1'b0, 4'd0,    5'b11001);
    step("single_b3", 1'b0, 4'd0,    5'b10011);
    step("single_end", 1'b0, 4'd0,   5'b00001);

    // 3+4: 1010, 1110, then 0101 offered while the buffer is full.
    step("b2b_c0",  1'b1, 4'b1010, 5'b11101);
    step("b2b_c1",  1'b1, 4'b1110, 5'b10000);
    step("b2b_c2",  1'b1, 4'b0101, 5'b11000);
    step("b2b_c3",  1'b1, 4'b0101, 5'b10010);
    step("b2b_c4",  1'b1, 4'b0101, 5'b11101);
    step("b2b_c5",  1'b1, 4'b0101, 5'b11000);
    step("b2b_c6",  1'b0, 4'd0,    5'b11000);
    step("b2b_c7",  1'b0, 4'd0,    5'b10010);
    step("b2b_c8",  1'b0, 4'd0,    5'b10101);
    step("b2b_c9",  1'b0, 4'd0,    5'b11001);
    step("b2b_c10", 1'b0, 4'd0,    5'b10001);
    step("b2b_c11", 1'b0, 4'd0,    5'b11011);
    step("b2b_end", 1'b0, 4'd0,    5'b00001);

    // 5: async reset after two bits, then a fresh word 0011.
    step("arst_b0", 1'b1, 4'b1010, 5'b11101);
    step("arst_b1", 1'b0, 4'd0,    5'b10001);
    #2 rst = 1'b0;
    #1 chk_out("arst_now", 5'b00001);
    @(negedge clk);
    chk_out("arst_hold", 5'b00001);
    rst = 1'b1;
    step("arst_w_b0", 1'b1, 4'b0011, 5'b10101);
    step("arst_w_b1", 1'b0, 4'd0,    5'b10001);
    step("arst_w_b2", 1'b0, 4'd0,    5'b11001);
    step("arst_w_b3", 1'b0, 4'd0,    5'b11011);
    step("arst_w_end", 1'b0, 4'd0,   5'b00001);

    // 6: LSB-first 4-bit 1010 and LSB-first 8-bit A5.
    exp_b = 4'b0101;
    exp_c = 8'b10100101;
    din_b = 4'b1010; din_valid_b = 1'b1;
    din_c = 8'hA5;   din_valid_c = 1'b1;
    @(posedge clk);
    @(negedge clk);
    din_valid_b = 1'b0; din_b = 4'bxxxx;
    din_valid_c = 1'b0; din_c = 8'hxx;
    for (int j = 0; j < 8; j++) begin
      chk($sformatf("lsb8_sout%0d", j),  {7'd0, sout_c},       {7'd0, exp_c[j]});
      chk($sformatf("lsb8_valid%0d", j), {7'd0, sout_valid_c}, 8'd1);
      chk($sformatf("lsb8_first%0d", j), {7'd0, sout_first_c}, (j == 0) ? 8'd1 : 8'd0);
      chk($sformatf("lsb8_last%0d", j),  {7'd0, sout_last_c},  (j == 7) ? 8'd1 : 8'd0);
      if (j < 4) begin
        chk($sformatf("lsb4_sout%0d", j),  {7'd0, sout_b},       {7'd0, exp_b[j]});
        chk($sformatf("lsb4_valid%0d", j), {7'd0, sout_valid_b}, 8'd1);
        chk($sformatf("lsb4_first%0d", j), {7'd0, sout_first_b}, (j == 0) ? 8'd1 : 8'd0);
        chk($sformatf("lsb4_last%0d", j),  {7'd0, sout_last_b},  (j == 3) ? 8'd1 : 8'd0);
      end else if (j == 4) begin
        chk("lsb4_end_valid", {7'd0, sout_valid_b}, 8'd0);
      end
      @(posedge clk);
      @(negedge clk);
    end
    chk("lsb8_end_valid", {7'd0, sout_valid_c}, 8'd0);
    chk("lsb8_end_ready", {7'd0, din_ready_c},  8'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
